// File: rtl/uart_controller_fifo_if.sv
// AXI4-Lite slave bus bundle for the UART register front end.
// The master modport is the interconnect side; the slave modport is the register block.
interface uart_controller_fifo_if #(
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int REG_ADDRESS_WIDTH = 5
);
    logic [REG_ADDRESS_WIDTH-1:0]   s_axi_awaddr_i;
    logic [2:0]                     s_axi_awprot_i;
    logic                           s_axi_awvalid_i;
    logic                           s_axi_awready_o;
    logic [AXI_DATA_WIDTH-1:0]      s_axi_wdata_i;
    logic [AXI_DATA_WIDTH/8-1:0]    s_axi_wstrb_i;
    logic                           s_axi_wvalid_i;
    logic                           s_axi_wready_o;
    logic [1:0]                     s_axi_bresp_o;
    logic                           s_axi_bvalid_o;
    logic                           s_axi_bready_i;
    logic [REG_ADDRESS_WIDTH-1:0]   s_axi_araddr_i;
    logic [2:0]                     s_axi_arprot_i;
    logic                           s_axi_arvalid_i;
    logic                           s_axi_arready_o;
    logic [AXI_DATA_WIDTH-1:0]      s_axi_rdata_o;
    logic [1:0]                     s_axi_rresp_o;
    logic                           s_axi_rvalid_o;
    logic                           s_axi_rready_i;

    modport master (
        output s_axi_awaddr_i, s_axi_awprot_i, s_axi_awvalid_i,
        input  s_axi_awready_o,
        output s_axi_wdata_i, s_axi_wstrb_i, s_axi_wvalid_i,
        input  s_axi_wready_o,
        input  s_axi_bresp_o, s_axi_bvalid_o,
        output s_axi_bready_i,
        output s_axi_araddr_i, s_axi_arprot_i, s_axi_arvalid_i,
        input  s_axi_arready_o,
        input  s_axi_rdata_o, s_axi_rresp_o, s_axi_rvalid_o,
        output s_axi_rready_i
    );

    modport slave (
        input  s_axi_awaddr_i, s_axi_awprot_i, s_axi_awvalid_i,
        output s_axi_awready_o,
        input  s_axi_wdata_i, s_axi_wstrb_i, s_axi_wvalid_i,
        output s_axi_wready_o,
        output s_axi_bresp_o, s_axi_bvalid_o,
        input  s_axi_bready_i,
        input  s_axi_araddr_i, s_axi_arprot_i, s_axi_arvalid_i,
        output s_axi_arready_o,
        output s_axi_rdata_o, s_axi_rresp_o, s_axi_rvalid_o,
        input  s_axi_rready_i
    );
endinterface

// File: rtl/uart_controller_fifo.sv
// AXI4-Lite register front end for the UART core with TX/RX FIFOs,
// sticky error flags, FIFO flush and a maskable level interrupt.
// One transmitter start is issued per TX FIFO entry.
module uart_controller_fifo #(
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int DATA_WIDTH        = 8,
    parameter int BAUD_VALUE_WIDTH  = 16,
    parameter int FIFO_DEPTH        = 16,
    parameter int REG_ADDRESS_WIDTH = 5
) (
    input  logic                        axi_clk_i,
    input  logic                        axi_rst_i,
    uart_controller_fifo_if.slave       s_axi,
    output logic                        tx_start_o,
    output logic [DATA_WIDTH-1:0]       tx_data_o,
    input  logic                        tx_complete_i,
    input  logic                        rx_valid_i,
    input  logic [DATA_WIDTH-1:0]       rx_data_i,
    output logic                        data_bit_num_o,
    output logic                        stop_bit_num_o,
    output logic [BAUD_VALUE_WIDTH-1:0] baud_tick_val_o,
    output logic                        irq_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WORD_W = REG_ADDRESS_WIDTH - 2;

    localparam logic [WORD_W-1:0] A_CTRL   = WORD_W'(0);
    localparam logic [WORD_W-1:0] A_BAUD   = WORD_W'(1);
    localparam logic [WORD_W-1:0] A_TXDATA = WORD_W'(2);
    localparam logic [WORD_W-1:0] A_RXDATA = WORD_W'(3);
    localparam logic [WORD_W-1:0] A_STATUS = WORD_W'(4);
    localparam logic [WORD_W-1:0] A_IRQ_EN = WORD_W'(5);

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_t;

    // AXI handshake state
    logic                      aw_ready, b_valid, ar_ready, r_valid;
    logic [AXI_DATA_WIDTH-1:0] r_data, rd_mux;
    logic                      wr_en, rd_en;
    logic [WORD_W-1:0]         wr_word, rd_word;

    // Registers
    logic                        ctrl_e, ctrl_d, ctrl_p, ctrl_s;
    logic                        tx_flush_pend, rx_flush_pend;
    logic [BAUD_VALUE_WIDTH-1:0] baud;
    logic [2:0]                  irq_en;
    logic                        tx_overflow, rx_overrun;
    logic                        irq;

    // TX FIFO
    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      tx_wr_ptr, tx_rd_ptr;
    logic [LVL_W-1:0]      tx_level;
    logic                  tx_empty, tx_full, tx_push_req, tx_push, tx_pop, tx_ovf_set;
    logic [DATA_WIDTH-1:0] tx_head;

    // RX FIFO
    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rx_wr_ptr, rx_rd_ptr;
    logic [LVL_W-1:0]      rx_level;
    logic                  rx_empty, rx_full, rx_push, rx_pop, rx_ovr_set;
    logic [DATA_WIDTH-1:0] rx_head;

    // Transmitter control
    tx_state_t             state, state_next;
    logic                  tx_busy;
    logic                  tx_start;
    logic [DATA_WIDTH-1:0] tx_data;

    // Address bits [1:0], prot and the unused upper data bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{s_axi.s_axi_awprot_i, s_axi.s_axi_arprot_i,
                           s_axi.s_axi_awaddr_i[1:0], s_axi.s_axi_araddr_i[1:0],
                           s_axi.s_axi_wdata_i, s_axi.s_axi_wstrb_i};

    assign wr_word = s_axi.s_axi_awaddr_i[REG_ADDRESS_WIDTH-1:2];
    assign rd_word = s_axi.s_axi_araddr_i[REG_ADDRESS_WIDTH-1:2];
    assign wr_en   = aw_ready & s_axi.s_axi_awvalid_i & s_axi.s_axi_wvalid_i;
    assign rd_en   = ar_ready & s_axi.s_axi_arvalid_i;

    assign s_axi.s_axi_awready_o = aw_ready;
    assign s_axi.s_axi_wready_o  = aw_ready;
    assign s_axi.s_axi_bresp_o   = 2'b00;
    assign s_axi.s_axi_bvalid_o  = b_valid;
    assign s_axi.s_axi_arready_o = ar_ready;
    assign s_axi.s_axi_rdata_o   = r_data;
    assign s_axi.s_axi_rresp_o   = 2'b00;
    assign s_axi.s_axi_rvalid_o  = r_valid;

    // Write channel: one-cycle ready pulse, then hold bvalid until accepted
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            aw_ready <= 1'b0;
            b_valid  <= 1'b0;
        end else begin
            aw_ready <= s_axi.s_axi_awvalid_i & s_axi.s_axi_wvalid_i & ~b_valid & ~aw_ready;
            if (wr_en)
                b_valid <= 1'b1;
            else if (s_axi.s_axi_bready_i)
                b_valid <= 1'b0;
        end
    end

    // Read channel: one-cycle ready pulse, data captured at the handshake edge
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            ar_ready <= s_axi.s_axi_arvalid_i & ~r_valid & ~ar_ready;
            if (rd_en) begin
                r_valid <= 1'b1;
                r_data  <= rd_mux;
            end else if (s_axi.s_axi_rready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Read data multiplexer
    always_comb begin
        rd_mux = '0;
        case (rd_word)
            A_CTRL: begin
                rd_mux[0]  = ctrl_e;
                rd_mux[4]  = ctrl_d;
                rd_mux[8]  = ctrl_p;
                rd_mux[12] = ctrl_s;
            end
            A_BAUD:   rd_mux[BAUD_VALUE_WIDTH-1:0] = baud;
            A_RXDATA: if (!rx_empty) rd_mux[DATA_WIDTH-1:0] = rx_head;
            A_STATUS: begin
                rd_mux[0]          = tx_empty;
                rd_mux[1]          = tx_full;
                rd_mux[2]          = rx_empty;
                rd_mux[3]          = rx_full;
                rd_mux[4]          = rx_overrun;
                rd_mux[5]          = tx_busy;
                rd_mux[6]          = tx_overflow;
                rd_mux[8 +: LVL_W]  = tx_level;
                rd_mux[16 +: LVL_W] = rx_level;
            end
            A_IRQ_EN: rd_mux[2:0] = irq_en;
            default:  rd_mux = '0;
        endcase
    end

    // Configuration registers with byte strobes; flush requests last exactly one cycle
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            ctrl_e        <= 1'b0;
            ctrl_d        <= 1'b0;
            ctrl_p        <= 1'b0;
            ctrl_s        <= 1'b0;
            tx_flush_pend <= 1'b0;
            rx_flush_pend <= 1'b0;
            baud          <= '0;
            irq_en        <= '0;
        end else begin
            tx_flush_pend <= wr_en && wr_word == A_CTRL && s_axi.s_axi_wstrb_i[2] && s_axi.s_axi_wdata_i[16];
            rx_flush_pend <= wr_en && wr_word == A_CTRL && s_axi.s_axi_wstrb_i[2] && s_axi.s_axi_wdata_i[17];
            if (wr_en && wr_word == A_CTRL) begin
                if (s_axi.s_axi_wstrb_i[0]) begin
                    ctrl_e <= s_axi.s_axi_wdata_i[0];
                    ctrl_d <= s_axi.s_axi_wdata_i[4];
                end
                if (s_axi.s_axi_wstrb_i[1]) begin
                    ctrl_p <= s_axi.s_axi_wdata_i[8];
                    ctrl_s <= s_axi.s_axi_wdata_i[12];
                end
            end
            if (wr_en && wr_word == A_BAUD) begin
                for (int i = 0; i < BAUD_VALUE_WIDTH; i++)
                    if (s_axi.s_axi_wstrb_i[i/8])
                        baud[i] <= s_axi.s_axi_wdata_i[i];
            end
            if (wr_en && wr_word == A_IRQ_EN && s_axi.s_axi_wstrb_i[0])
                irq_en <= s_axi.s_axi_wdata_i[2:0];
        end
    end

    assign data_bit_num_o  = ctrl_d;
    assign stop_bit_num_o  = ctrl_s;
    assign baud_tick_val_o = baud;

    // TX FIFO flags and push/pop qualification; a push during a flush cycle is discarded
    assign tx_empty    = (tx_level == '0);
    assign tx_full     = (tx_level == LVL_W'(FIFO_DEPTH));
    assign tx_head     = tx_mem[tx_rd_ptr];
    assign tx_pop      = (state == TX_LOAD);
    assign tx_push_req = wr_en && wr_word == A_TXDATA && s_axi.s_axi_wstrb_i[0] && !tx_flush_pend;
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_ovf_set  = tx_push_req && tx_full && !tx_pop;

    // TX FIFO pointers and level
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i || tx_flush_pend) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + LVL_W'(1);
                2'b01:   tx_level <= tx_level - LVL_W'(1);
                default: tx_level <= tx_level;
            endcase
        end
    end

    // TX FIFO storage
    always_ff @(posedge axi_clk_i) begin
        if (tx_push)
            tx_mem[tx_wr_ptr] <= s_axi.s_axi_wdata_i[DATA_WIDTH-1:0];
    end

    // RX FIFO flags; a pop in the same cycle makes room for an incoming character
    assign rx_empty   = (rx_level == '0);
    assign rx_full    = (rx_level == LVL_W'(FIFO_DEPTH));
    assign rx_head    = rx_mem[rx_rd_ptr];
    assign rx_pop     = rd_en && rd_word == A_RXDATA && !rx_empty;
    assign rx_push    = rx_valid_i && !rx_flush_pend && (!rx_full || rx_pop);
    assign rx_ovr_set = rx_valid_i && !rx_flush_pend && rx_full && !rx_pop;

    // RX FIFO pointers and level
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i || rx_flush_pend) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + LVL_W'(1);
                2'b01:   rx_level <= rx_level - LVL_W'(1);
                default: rx_level <= rx_level;
            endcase
        end
    end

    // RX FIFO storage
    always_ff @(posedge axi_clk_i) begin
        if (rx_push)
            rx_mem[rx_wr_ptr] <= rx_data_i;
    end

    // Sticky error flags: write-1-to-clear, a new error in the same cycle wins
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            tx_overflow <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            if (tx_ovf_set)
                tx_overflow <= 1'b1;
            else if (wr_en && wr_word == A_STATUS && s_axi.s_axi_wdata_i[6])
                tx_overflow <= 1'b0;
            if (rx_ovr_set)
                rx_overrun <= 1'b1;
            else if (wr_en && wr_word == A_STATUS && s_axi.s_axi_wdata_i[4])
                rx_overrun <= 1'b0;
        end
    end

    // Transmitter FSM state register
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i)
            state <= TX_IDLE;
        else
            state <= state_next;
    end

    // Transmitter FSM next state; no new load while a TX flush is about to empty the FIFO
    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE: if (ctrl_e && !tx_empty && !tx_flush_pend) state_next = TX_LOAD;
            TX_LOAD: state_next = TX_BUSY;
            TX_BUSY: if (tx_complete_i) state_next = TX_IDLE;
            default: state_next = TX_IDLE;
        endcase
    end

    assign tx_busy = (state != TX_IDLE);

    // Start pulse and character register, launched together when leaving LOAD
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= (state == TX_LOAD);
            if (state == TX_LOAD)
                tx_data <= tx_head;
        end
    end

    assign tx_start_o = tx_start;
    assign tx_data_o  = tx_data;

    // Registered level-sensitive interrupt
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i)
            irq <= 1'b0;
        else
            irq <= |(irq_en & {tx_overflow | rx_overrun, !rx_empty, tx_empty & !tx_busy});
    end

    assign irq_o = irq;

endmodule

// File: doc/uart_controller_fifo.md
Name: uart_controller_fifo

Overview:
- Next-generation AXI4-Lite register front end for the UART core: owns the configuration, baud and status registers and drives the transmitter.
- Adds a parametrised TX FIFO and RX FIFO with level reporting, sticky overflow/overrun flags, FIFO flush, and a maskable level-sensitive interrupt.
- Sits between the AXI-Lite interconnect and the UART tx/rx engines; one transmitter start per FIFO entry.

Parameters:
- AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- DATA_WIDTH, 8: UART character width; 5..8.
- BAUD_VALUE_WIDTH, 16: baud tick divider width; 1..32.
- FIFO_DEPTH, 16: entries per FIFO; power of two, 2..128.
- REG_ADDRESS_WIDTH, 5: byte address width; 8 word registers.

Ports:
- axi_clk_i  in  1  single clock.
- axi_rst_i  in  1  synchronous reset, active-high.
- s_axi_awaddr_i  in  REG_ADDRESS_WIDTH  write address; s_axi_awprot_i  in  3  ignored.
- s_axi_awvalid_i  in  1 / s_axi_awready_o  out  1  write address handshake.
- s_axi_wdata_i  in  AXI_DATA_WIDTH / s_axi_wstrb_i  in  AXI_DATA_WIDTH/8  write data and byte strobes.
- s_axi_wvalid_i  in  1 / s_axi_wready_o  out  1  write data handshake.
- s_axi_bresp_o  out  2 / s_axi_bvalid_o  out  1 / s_axi_bready_i  in  1  write response.
- s_axi_araddr_i  in  REG_ADDRESS_WIDTH / s_axi_arprot_i  in  3 (ignored) / s_axi_arvalid_i  in  1 / s_axi_arready_o  out  1  read address.
- s_axi_rdata_o  out  AXI_DATA_WIDTH / s_axi_rresp_o  out  2 / s_axi_rvalid_o  out  1 / s_axi_rready_i  in  1  read data.
- tx_start_o  out  1  one-cycle pulse: start transmitting tx_data_o.
- tx_data_o  out  DATA_WIDTH  character; held stable from tx_start_o until tx_complete_i.
- tx_complete_i  in  1  one-cycle pulse from the transmitter at stop-bit end.
- rx_valid_i  in  1 / rx_data_i  in  DATA_WIDTH  received character strobe and data.
- data_bit_num_o  out  1 / stop_bit_num_o  out  1 / baud_tick_val_o  out  BAUD_VALUE_WIDTH  configuration fields, driven directly from registers.
- irq_o  out  1  interrupt, registered.

Behaviour:
- Register map (word aligned):
  - 0x00 CTRL: bit0 E (tx enable), bit4 D, bit8 P, bit12 S; bit16 TXFLUSH and bit17 RXFLUSH are self-clearing and read 0.
  - 0x04 BAUD: [BAUD_VALUE_WIDTH-1:0].
  - 0x08 TXDATA: write pushes wdata[DATA_WIDTH-1:0] if wstrb[0]; reads 0.
  - 0x0C RXDATA: a read returns the head in [DATA_WIDTH-1:0] and pops it; an empty FIFO returns 0 with no pop.
  - 0x10 STATUS:
    - bit0 tx_empty, bit1 tx_full, bit2 rx_empty, bit3 rx_full.
    - bit4 rx_overrun, bit6 tx_overflow: sticky, write-1-to-clear.
    - bit5 tx_busy.
    - [15:8] tx level, [23:16] rx level.
  - 0x14 IRQ_EN: bit0 tx_empty, bit1 rx not empty, bit2 either sticky error.
  - Unmapped addresses: writes ignored, reads 0.
- Byte strobes apply to CTRL, BAUD and IRQ_EN. bresp and rresp are always 2'b00.
- Write channel:
  - awready_o and wready_o pulse together for one cycle when awvalid_i and wvalid_i are both high and bvalid_o is low.
  - The register update happens on that edge. bvalid_o rises the next cycle and stays high until bready_i is sampled high.
  - No outstanding transactions beyond one.
- Read channel:
  - arready_o pulses for one cycle when arvalid_i is high and rvalid_o is low.
  - rdata_o and rvalid_o are registered the next cycle and held until rready_i. The RX pop occurs at the arready handshake.
- TX FSM, states IDLE, LOAD, BUSY:
  - IDLE -> LOAD when E=1 and the TX FIFO is not empty.
  - LOAD: pop the head into the tx_data_o register and pulse tx_start_o for one cycle; go to BUSY.
  - BUSY -> IDLE on tx_complete_i. tx_busy = (state != IDLE).
  - Clearing E mid-character: the current character completes, and the next is not started.
  - Minimum gap between characters: LOAD to the next LOAD is at least 2 cycles after tx_complete_i.
- FIFOs: synchronous, registered pointers; level width is clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- Boundary rules:
  - TXDATA write while TX full: data dropped, tx_overflow set.
  - rx_valid_i while RX full with no pop in the same cycle: character dropped, rx_overrun set.
  - Simultaneous push and pop: both take effect and the level is unchanged; this applies when full too.
  - Pop from an empty TX FIFO cannot occur.
  - TXFLUSH/RXFLUSH zero the pointers and level in the cycle after the write. An in-flight character finishes. A push in the flush cycle is discarded.
  - Sticky W1C set and clear in the same cycle: set wins.
- irq_o = |(IRQ_EN & {sticky_err_any, !rx_empty, tx_empty & !tx_busy}), registered (1-cycle latency).
- Reset: all registers and FIFO pointers cleared.
  - All outputs 0, including tx_data_o, tx_start_o, bvalid_o, rvalid_o, irq_o, baud_tick_val_o and config bits.
  - FSM to IDLE. Reset mid-transfer abandons the AXI transaction and FIFO contents.

Test Plan:
- Write BAUD=0x0000_01B2, CTRL=0x0000_1011 -> baud_tick_val_o=0x01B2, E=1, D=1, S=1; readback of both equals the written values; bresp=0.
- With E=0, push 0x41, 0x42, 0x43 -> STATUS[15:8]=3. Set E=1 -> tx_start_o pulses with 0x41, then 0x42 after tx_complete_i, then 0x43, in order. Final STATUS tx_empty=1, tx_busy=0.
- Push FIFO_DEPTH+1 bytes with E=0 -> tx_full=1, tx_overflow=1. Writing 0x40 to STATUS clears bit6 only.
- Drive rx_valid_i with 0x10..0x10+FIFO_DEPTH (DEPTH+1 chars) -> rx_full=1, rx_overrun=1. RXDATA reads return 0x10 upward; the extra character is absent; an empty-FIFO read returns 0.
- IRQ_EN=0x2, single rx char 0x5A -> irq_o high 1 cycle after the push; RXDATA read returns 0x5A; irq_o low after the pop.
- Assert axi_rst_i while in BUSY with 3 TX entries queued -> next cycle: all outputs 0, levels 0; no tx_start_o after release until a new push.
